rf_writeback_arbiter: RTL
=========================

// Module: rf_writeback_arbiter
// PURPOSE
//  Owns the single write port of the register file, the writer end of its interface.
//  Merges two write sources: the in-order pipeline WB stage (primary, never stalls)
//  and the multi-cycle MDU result bus (valid/ready).
//  Buffers MDU results in a small FIFO. Keeps a pending-write scoreboard for
//  hazard detection in ID.
// PARAMETERS
//  DATA_W        32  register data width
//  REG_AW        5   register address width (32 architectural regs, r0 hardwired 0)
//  FIFO_DEPTH    2   MDU result buffer entries (power of 2, >=2)
//  STARVE_LIMIT  4   cycles a full-FIFO head may wait before stall_req asserts
// PORTS
//  clk             in   1        clock; all state on posedge
//  reset           in   1        asynchronous, active-high
//  pipe_wb_en      in   1        pipeline WB write request this cycle
//  pipe_wb_reg     in   REG_AW   pipeline destination register
//  pipe_wb_data    in   DATA_W   pipeline write data
//  mdu_issue       in   1        MDU op issued in ID this cycle
//  mdu_issue_reg   in   REG_AW   destination of issued MDU op
//  mdu_valid       in   1        MDU result valid
//  mdu_ready       out  1        arbiter accepts MDU result
//  mdu_reg         in   REG_AW   MDU result destination
//  mdu_data        in   DATA_W   MDU result data
//  RegWrite        out  1        register file write enable
//  Write_register  out  REG_AW   register file write address
//  Write_data      out  DATA_W   register file write data
//  pending         out  32       bit i = MDU write to ri outstanding (bit 0 always 0)
//  stall_req       out  1        pipeline must send no WB write (pipe_wb_en=0) next cycle
// BEHAVIOUR
//  Reset values:
//   - FIFO empty, pending=0, starve counter=0, stall_req=0.
//   - While reset is high: RegWrite=0, mdu_ready=0.
//  Port arbitration is combinational each cycle, highest priority first:
//   1) pipe_wb_en && pipe_wb_reg!=0: drive the pipeline write.
//   2) Else if FIFO not empty: pop the head and drive it.
//   3) Else if mdu_valid: drive the MDU write directly. Zero latency, not enqueued.
//   4) Else RegWrite=0. Write_register/Write_data are don't-care but driven 0.
//  A pipeline write to r0 counts as no request, so the port is free for MDU traffic.
//  mdu_ready = !full || pop this cycle.
//  Handshake completes when mdu_valid && mdu_ready. The MDU must hold its data until then.
//   - Accepted and not bypassed (case 3): enqueue at tail.
//   - Push and pop in the same cycle are legal when full; occupancy is unchanged.
//   - A result with mdu_reg==0 is accepted and discarded. No enqueue, no write.
//  Order: MDU results commit in acceptance order. Bypass happens only when the FIFO is empty.
//  Scoreboard:
//   - mdu_issue && mdu_issue_reg!=0 sets pending[mdu_issue_reg].
//   - An MDU write to rN on the port (pop or bypass) clears pending[N].
//   - Set and clear of the same bit in one cycle: set wins (back-to-back issue).
//  WAW rule: ID stalls on pending, so a pipeline write to a pending register is illegal.
//  Starvation:
//   - The counter increments each cycle the FIFO is full and no pop occurs.
//   - It clears on any pop.
//   - stall_req is registered: it goes high the cycle after count reaches STARVE_LIMIT.
//   - While stall_req is high the pipeline drives pipe_wb_en=0, so the head pops
//     and the counter clears. stall_req then drops the following cycle.
//  Asynchronous reset mid-operation drops all queued results and clears pending.
//  The MDU is reset by the same signal.
// STRUCTURE
//  rf_pkg: DATA_W, REG_AW, ZERO_REG=5'd0, and a wb_req_t {en, reg, data} struct
//  shared with the WB stage and the register file.
//  Sub-module wb_fifo: FIFO_DEPTH entries of {reg, data}.
//   - Interfaces: push/pop/full/empty/head, async reset.
//   - Pointers wrap modulo FIFO_DEPTH, with an extra bit to tell full from empty.
//  Arbitration, scoreboard and starve counter stay in this module.
// TESTING
//  1) MDU result r5=0x1234, pipe idle, FIFO empty
//     -> RegWrite=1, Write_register=5, Write_data=0x1234 in the same cycle.
//     -> pending[5] clears at the next edge.
//  2) Pipe writes r3=0xA every cycle; MDU presents r7=0xB, then r8=0xC
//     -> both enqueue and mdu_ready drops when full.
//     -> stall_req rises after STARVE_LIMIT full cycles.
//     -> Bubble cycle writes r7=0xB, the next free cycle writes r8=0xC.
//  3) FIFO full, pipe idle, mdu_valid with r9
//     -> simultaneous pop and push; occupancy stays 2; order is preserved.
//  4) mdu_issue r4 in the same cycle as an MDU commit to r4
//     -> pending[4] stays 1.
//  5) Pipe write to r0 while the FIFO holds r6=0x55 -> r6 is written that cycle.
//     MDU result to r0 -> accepted, no write.
//  6) Assert reset with 2 entries queued and pending=0x0000_0180
//     -> FIFO empty, pending=0, RegWrite=0 immediately; no stale writes after release.

Source files
------------

// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared register-file types: widths, the zero register and the write request
// record exchanged between WB stage, arbiter and register file.
package rf_writeback_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] wreg;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic [REG_AW-1:0] wreg;
    logic [DATA_W-1:0] data;
  } mdu_res_t;

  function automatic logic [31:0] reg_onehot(input logic [REG_AW-1:0] r);
    return 32'd1 << r;
  endfunction

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// MDU result channel: valid/ready handshake carrying destination and data.
interface rf_writeback_arbiter_if;
  import rf_writeback_arbiter_pkg::*;

  logic              valid;
  logic              ready;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] data;

  modport master (output valid, output rd, output data, input ready);
  modport slave  (input valid, input rd, input data, output ready);
endinterface

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// MDU result buffer; pointers carry one extra wrap bit to tell full from empty.
module rf_writeback_arbiter_wb_fifo
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  mdu_res_t entry_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output mdu_res_t head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  mdu_res_t       mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      // A push into a full FIFO only happens alongside a pop, so the slot is free.
      if (push_i) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= entry_i;
      end
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write port owner: merges pipeline WB writes with buffered MDU
// results, tracks outstanding MDU destinations and requests a bubble on starvation.
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pipe_wb_en_i,
  input  logic [REG_AW-1:0]      pipe_wb_reg_i,
  input  logic [DATA_W-1:0]      pipe_wb_data_i,
  input  logic                   mdu_issue_i,
  input  logic [REG_AW-1:0]      mdu_issue_reg_i,
  rf_writeback_arbiter_if.slave  mdu,
  output logic                   RegWrite_o,
  output logic [REG_AW-1:0]      Write_register_o,
  output logic [DATA_W-1:0]      Write_data_o,
  output logic [31:0]            pending_o,
  output logic                   stall_req_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             pipe_req_s, mdu_nz_s, accept_s, bypass_s, push_s, pop_s;
  logic             full_s, empty_s;
  mdu_res_t         head_s, entry_s;
  wb_req_t          wreq_s;
  logic [31:0]      pending_q, pending_d, clr_mask_s, set_mask_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;

  assign pipe_req_s = pipe_wb_en_i && (pipe_wb_reg_i != ZERO_REG);
  assign mdu_nz_s   = (mdu.rd != ZERO_REG);
  assign pop_s      = !reset && !pipe_req_s && !empty_s;
  assign mdu.ready  = !reset && (!full_s || pop_s);
  assign accept_s   = mdu.valid && mdu.ready;
  assign bypass_s   = accept_s && mdu_nz_s && !pipe_req_s && empty_s;
  assign push_s     = accept_s && mdu_nz_s && !bypass_s;
  assign entry_s    = '{wreg: mdu.rd, data: mdu.data};

  rf_writeback_arbiter_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .entry_i (entry_s),
    .pop_i   (pop_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .head_o  (head_s)
  );

  always_comb begin
    wreq_s = '0;
    if (reset) begin
      wreq_s = '0;
    end else if (pipe_req_s) begin
      wreq_s = '{en: 1'b1, wreg: pipe_wb_reg_i, data: pipe_wb_data_i};
    end else if (pop_s) begin
      wreq_s = '{en: 1'b1, wreg: head_s.wreg, data: head_s.data};
    end else if (bypass_s) begin
      wreq_s = '{en: 1'b1, wreg: mdu.rd, data: mdu.data};
    end else begin
      wreq_s = '0;
    end
  end

  assign RegWrite_o       = wreq_s.en;
  assign Write_register_o = wreq_s.wreg;
  assign Write_data_o     = wreq_s.data;

  // Set is applied after clear so a back-to-back issue keeps its bit.
  always_comb begin
    clr_mask_s = 32'd0;
    set_mask_s = 32'd0;
    if (pop_s || bypass_s) begin
      clr_mask_s = reg_onehot(wreq_s.wreg);
    end else begin
      clr_mask_s = 32'd0;
    end
    if (mdu_issue_i && (mdu_issue_reg_i != ZERO_REG)) begin
      set_mask_s = reg_onehot(mdu_issue_reg_i);
    end else begin
      set_mask_s = 32'd0;
    end
    pending_d    = (pending_q & ~clr_mask_s) | set_mask_s;
    pending_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (pop_s) begin
      cnt_d = '0;
    end else if (full_s && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    stall_d = (cnt_q == LIMIT) && !pop_s;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 32'd0;
      cnt_q     <= '0;
      stall_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      stall_q   <= stall_d;
    end
  end

  assign pending_o   = pending_q;
  assign stall_req_o = stall_q;

endmodule
